// File: rtl/acc_driver.sv
// acc_driver: sequences a host-loaded batch of 4x int8 vectors into the accelerator
// and captures one result per vector. `define ACC_DRV_TIMEOUT_EN adds a WAIT_RES watchdog.
module acc_driver #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic [ADDR_W:0]   count,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic signed [7:0] X1,
  output logic signed [7:0] X2,
  output logic signed [7:0] X3,
  output logic signed [7:0] X4,
  output logic              valid,
  input  logic              ready,
  input  logic signed [7:0] Y,
  input  logic              valid_out,
  output logic              ready_out,
  input  logic [ADDR_W-1:0] res_addr,
  output logic [7:0]        res_data,
  output logic              timeout
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_RES, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] SLOT0   = '0;

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W:0]   cnt_q;
  logic [31:0]       x_q;
  logic              valid_q, ready_out_q, busy_q, done_q, timeout_q;
  logic [7:0]        res_data_q;

  logic [31:0] vec_mem [DEPTH];
  logic [7:0]  res_mem [DEPTH];

  logic              host_we, res_hs, to_hit, res_we, last;
  logic [ADDR_W-1:0] idx_nxt;
  logic [7:0]        res_wdata;

  assign host_we   = load_we && (state_q == IDLE);
  assign res_hs    = (state_q == WAIT_RES) && valid_out && ready_out_q;
  assign res_we    = res_hs || to_hit;
  assign res_wdata = res_hs ? Y : 8'h80;
  assign idx_nxt   = idx_q + 1'b1;
  assign last      = ({1'b0, idx_q} == cnt_q - 1'b1);

`ifdef ACC_DRV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_q;

  // Held at zero outside WAIT_RES, so every entry starts a fresh count.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst)                    tcnt_q <= '0;
    else if (state_q != WAIT_RES) tcnt_q <= '0;
    else                          tcnt_q <= tcnt_q + 1'b1;
  end

  assign to_hit = (state_q == WAIT_RES) && !res_hs && (tcnt_q == TW'(TIMEOUT - 1));
`else
  assign to_hit = (TIMEOUT < 0);
`endif

  // Memories carry no reset; writes are gated by state, which reset forces to IDLE.
  always_ff @(posedge clk) begin
    if (host_we) vec_mem[load_addr] <= load_data;
    if (res_we)  res_mem[idx_q]     <= res_wdata;
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      x_q         <= '0;
      valid_q     <= 1'b0;
      ready_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      res_data_q  <= '0;
    end else begin
      res_data_q <= res_mem[res_addr];
      done_q     <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          busy_q    <= 1'b1;
          timeout_q <= 1'b0;
          idx_q     <= '0;
          if (count == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q   <= (count > DEPTH_C) ? DEPTH_C : count;
            // forward a same-cycle host write to slot 0 into the first vector
            x_q     <= (load_we && load_addr == SLOT0) ? load_data : vec_mem[SLOT0];
            valid_q <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: if (ready) begin
          valid_q     <= 1'b0;
          ready_out_q <= 1'b1;
          state_q     <= WAIT_RES;
        end
        WAIT_RES: if (res_we) begin
          ready_out_q <= 1'b0;
          if (to_hit) timeout_q <= 1'b1;
          state_q     <= DRAIN;
        end
        DRAIN: if (!valid_out) begin
          if (last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= idx_nxt;
            x_q     <= vec_mem[idx_nxt];
            valid_q <= 1'b1;
            state_q <= SEND;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {X4, X3, X2, X1} = x_q;
  assign valid     = valid_q;
  assign ready_out = ready_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign res_data  = res_data_q;

endmodule
